// File: rtl/fxp_div.sv
// rtl/fxp_div.sv - signed Q-format fixed-point divider, non-restoring, one divide in flight.
// Truncates toward zero; saturates the quotient and flags divide-by-zero and overflow.
module fxp_div #(
  parameter int W = 32,
  parameter int F = 0
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dz,
  output logic         ovf
);

  localparam int N  = W + F;
  localparam int CW = $clog2(N);
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [N-1:0] QLIM_P  = N'(POS_MAX);
  localparam logic [N-1:0] QLIM_N  = N'(POS_MAX) + N'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, HOLD} state_t;

  state_t          state, state_nxt;
  logic [W:0]      acc;
  logic [N-1:0]    qreg;
  logic [W-1:0]    den;
  logic [W-1:0]    dvd;
  logic            sign_q, sign_r, div_zero;
  logic [CW-1:0]   count;

  logic            accept;
  logic [W-1:0]    dvd_mag, dsr_mag;
  logic [N-1:0]    num_init;
  logic [W:0]      a_sh, a_new;
  logic [N-1:0]    q_new;
  logic [W-1:0]    r_mag, r_fix, q_fix;
  logic            ovf_fix;

  assign in_ready = nrst && (state == IDLE);
  assign accept   = en && in_valid && in_ready;

  // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude
  assign dvd_mag  = dividend[W-1] ? -dividend : dividend;
  assign dsr_mag  = divisor[W-1] ? -divisor : divisor;
  assign num_init = N'(dvd_mag) << F;

  // one non-restoring step: shift A:Q, add or subtract by sign of A
  assign a_sh  = {acc[W-1:0], qreg[N-1]};
  assign a_new = acc[W] ? (a_sh + {1'b0, den}) : (a_sh - {1'b0, den});
  assign q_new = {qreg[N-2:0], ~a_new[W]};

  // a negative A is >= -den, so the W-bit wrapped sum is the restored remainder
  assign r_mag = acc[W-1:0] + (acc[W] ? den : '0);

  always_comb begin
    q_fix   = sign_q ? -qreg[W-1:0] : qreg[W-1:0];
    r_fix   = sign_r ? -r_mag : r_mag;
    ovf_fix = 1'b0;
    if (div_zero) begin
      q_fix = sign_r ? NEG_MIN : POS_MAX;
      r_fix = dvd;
    end else if (!sign_q && (qreg > QLIM_P)) begin
      q_fix   = POS_MAX;
      ovf_fix = 1'b1;
    end else if (sign_q && (qreg > QLIM_N)) begin
      q_fix   = NEG_MIN;
      ovf_fix = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (divisor == '0) ? FIX : RUN;
      RUN:  if (en && (count == CW'(N-1))) state_nxt = FIX;
      FIX:  if (en) state_nxt = HOLD;
      HOLD: if (en && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc       <= '0;
      qreg      <= '0;
      den       <= '0;
      dvd       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      div_zero  <= 1'b0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= '0;
            qreg     <= num_init;
            den      <= dsr_mag;
            dvd      <= dividend;
            sign_q   <= dividend[W-1] ^ divisor[W-1];
            sign_r   <= dividend[W-1];
            div_zero <= (divisor == '0);
            count    <= '0;
          end
        end
        RUN: begin
          acc   <= a_new;
          qreg  <= q_new;
          count <= count + CW'(1);
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
          dz        <= div_zero;
          ovf       <= ovf_fix;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_div.sv
// tb/tb_fxp_div.sv - scoreboard bench for fxp_div with a Q0 and a Q16 instance.
module tb_fxp_div;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ovf;
    int          lat;
    int          raw;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b1;
  logic        iv [2];
  logic        ir [2];
  logic        ov [2];
  logic        ordy [2];
  logic        dzf [2];
  logic        ovff [2];
  logic [31:0] dd [2];
  logic [31:0] ds [2];
  logic [31:0] qo [2];
  logic [31:0] ro [2];

  exp_t sbq0[$];
  exp_t sbq1[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt = 0;
  int   cyc = 0;
  int   acc_e [2];
  int   acc_c [2];
  logic ov_prev [2];

  always #5 clk = ~clk;

  fxp_div #(.W(32), .F(0)) u_q0 (
    .clk(clk), .nrst(nrst), .en(en),
    .in_valid(iv[0]), .in_ready(ir[0]), .dividend(dd[0]), .divisor(ds[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .quotient(qo[0]), .remainder(ro[0]),
    .dz(dzf[0]), .ovf(ovff[0])
  );

  fxp_div #(.W(32), .F(16)) u_q16 (
    .clk(clk), .nrst(nrst), .en(en),
    .in_valid(iv[1]), .in_ready(ir[1]), .dividend(dd[1]), .divisor(ds[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .quotient(qo[1]), .remainder(ro[1]),
    .dz(dzf[1]), .ovf(ovff[1])
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en) ecnt <= ecnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  // monitor: pops one expectation per rising out_valid
  always @(negedge clk) begin
    exp_t e;
    bit   got;
    for (int i = 0; i < 2; i++) begin
      if (nrst && ov[i] && !ov_prev[i]) begin
        got = 1'b0;
        if (i == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); got = 1'b1; end
        if (i == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); got = 1'b1; end
        if (!got) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid inst %0d actual 1 required 0", i);
        end else begin
          chk($sformatf("quotient_%0d", i), 64'(qo[i]), 64'(e.q));
          chk($sformatf("remainder_%0d", i), 64'(ro[i]), 64'(e.r));
          chk($sformatf("dz_%0d", i), 64'(dzf[i]), 64'(e.dz));
          chk($sformatf("ovf_%0d", i), 64'(ovff[i]), 64'(e.ovf));
          chk($sformatf("latency_en_%0d", i), 64'(ecnt - acc_e[i]), 64'(e.lat));
          chk($sformatf("latency_clk_%0d", i), 64'(cyc - acc_c[i]), 64'(e.raw));
        end
      end
      ov_prev[i] = ov[i];
    end
  end

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input logic eovf, input int elat, input int eraw);
    exp_t e;
    int   t;
    iv[i] = 1'b1;
    dd[i] = a;
    ds[i] = b;
    t = 0;
    while (!(ir[i] && en) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst %0d actual busy required ready", i);
      iv[i] = 1'b0;
      return;
    end
    @(negedge clk);
    iv[i] = 1'b0;
    dd[i] = $urandom;
    ds[i] = $urandom;
    acc_e[i] = ecnt;
    acc_c[i] = cyc;
    e.q = eq; e.r = er; e.dz = edz; e.ovf = eovf; e.lat = elat; e.raw = eraw;
    if (i == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  task automatic wait_idle(input int i);
    int t;
    t = 0;
    while (((i == 0 ? sbq0.size() : sbq1.size()) > 0 || ov[i]) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL result_timeout inst %0d actual pending required done", i);
    end
  endtask

  task automatic run(input int i, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er,
                     input logic edz, input logic eovf, input int elat);
    issue(i, a, b, eq, er, edz, eovf, elat, elat);
    wait_idle(i);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; dd[i] = '0; ds[i] = '0;
      ov_prev[i] = 1'b0; acc_e[i] = 0; acc_c[i] = 0;
    end
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(ov[0]), 64'(0));
    chk("rst_quotient", 64'(qo[0]), 64'(0));
    chk("rst_remainder", 64'(ro[0]), 64'(0));
    chk("rst_dz", 64'(dzf[0]), 64'(0));
    chk("rst_ovf", 64'(ovff[0]), 64'(0));
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_0", 64'(ir[0]), 64'(1));
    chk("rst_in_ready_1", 64'(ir[1]), 64'(1));

    // Q0 directed vectors
    run(0, 32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 33);
    run(0, 32'hFFFFFF9C,  32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 1'b0, 33);
    run(0, 32'd100,       32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 1'b0, 33);
    run(0, 32'hFFFFFF9C,  32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 1'b0, 33);
    run(0, 32'h80000000,  32'hFFFFFFFF,   32'h7FFFFFFF,   32'd0,          1'b0, 1'b1, 33);
    run(0, 32'h80000000,  32'd1,          32'h80000000,   32'd0,          1'b0, 1'b0, 33);
    run(0, 32'd0,         32'd5,          32'd0,          32'd0,          1'b0, 1'b0, 33);
    run(0, 32'd5,         32'd0,          32'h7FFFFFFF,   32'd5,          1'b1, 1'b0, 1);
    run(0, 32'hFFFFFFFB,  32'd0,          32'h80000000,   32'hFFFFFFFB,   1'b1, 1'b0, 1);
    run(0, 32'd0,         32'd0,          32'h7FFFFFFF,   32'd0,          1'b1, 1'b0, 1);

    // Q16 directed vectors
    run(1, 32'h00018000,  32'h00008000,   32'h00030000,   32'd0,          1'b0, 1'b0, 49);
    run(1, 32'h00010000,  32'h00030000,   32'h00005555,   32'h00010000,   1'b0, 1'b0, 49);
    run(1, 32'h7FFF0000,  32'h00000001,   32'h7FFFFFFF,   32'd0,          1'b0, 1'b1, 49);
    run(1, 32'hFFFE8000,  32'h00008000,   32'hFFFD0000,   32'd0,          1'b0, 1'b0, 49);

    // back-pressure: result held, no second accept
    ordy[0] = 1'b0;
    issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, 33);
    t = 0;
    while (!ov[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 10; k++) begin
      iv[0] = 1'b1; dd[0] = 32'd9; ds[0] = 32'd1;
      @(negedge clk);
      chk("hold_out_valid", 64'(ov[0]), 64'(1));
      chk("hold_quotient", 64'(qo[0]), 64'(14));
      chk("hold_remainder", 64'(ro[0]), 64'(2));
      chk("hold_in_ready", 64'(ir[0]), 64'(0));
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    wait_idle(0);
    repeat (40) @(negedge clk);
    chk("after_hold_in_ready", 64'(ir[0]), 64'(1));

    // clock-enable freeze mid-RUN
    issue(0, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 38);
    repeat (10) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_idle(0);

    // asynchronous reset mid-RUN
    issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, 33);
    repeat (10) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov[0]), 64'(0));
    chk("midrst_quotient", 64'(qo[0]), 64'(0));
    chk("midrst_remainder", 64'(ro[0]), 64'(0));
    chk("midrst_dz", 64'(dzf[0]), 64'(0));
    chk("midrst_ovf", 64'(ovff[0]), 64'(0));
    sbq0.delete();
    @(negedge clk);
    nrst = 1'b1;
    repeat (60) @(negedge clk);
    chk("postrst_out_valid", 64'(ov[0]), 64'(0));
    chk("postrst_in_ready", 64'(ir[0]), 64'(1));
    run(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
